// File: rtl/z80_mem_decoder.sv
// Z80 memory-request front end: region decode, wait-state insertion, registered read data.
// Optional sticky decode-fault flag enabled by defining Z80_DECODE_FAULT_EN.
module z80_mem_decoder #(
  parameter logic [15:0] ROM_BASE   = 16'h0000,
  parameter int          ROM_ADDR_W = 14,
  parameter logic [15:0] RAM_BASE   = 16'h8000,
  parameter int          RAM_ADDR_W = 14,
  parameter int          ROM_WAIT   = 1,
  parameter int          RAM_WAIT   = 0,
  parameter logic [7:0]  OPEN_BUS   = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_mreq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  output logic        cpu_wait_n,
  output logic [7:0]  cpu_din,
  output logic        rom_ena,
  input  logic [7:0]  rom_dout,
  input  logic        rom_mwait,
  output logic        ram_ena,
  output logic        ram_we,
  input  logic [7:0]  ram_dout,
  input  logic        ram_mwait
`ifdef Z80_DECODE_FAULT_EN
  ,
  output logic        fault,
  input  logic        fault_clr
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {REG_NONE, REG_ROM, REG_RAM} region_t;

  localparam logic [3:0] ROM_WAIT_C = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);

  state_t      state, state_next;
  region_t     region, region_nxt, hit;
  logic        write, write_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        armed, armed_nxt;
  logic        rom_ena_nxt, ram_ena_nxt, wait_n_nxt;
  logic [7:0]  din_nxt;
  logic        start, slave_ready, complete;
  logic        addr_unused;

  // The slaves see the low address bits directly; only the high bits decode here.
  assign addr_unused = ^cpu_addr;
  assign start = !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n);

  always_comb begin
    hit = REG_NONE;
    if (cpu_addr[15:ROM_ADDR_W] == ROM_BASE[15:ROM_ADDR_W])
      hit = REG_ROM;
    else if (cpu_addr[15:RAM_ADDR_W] == RAM_BASE[15:RAM_ADDR_W])
      hit = REG_RAM;
  end

  always_comb begin
    case (region)
      REG_ROM: slave_ready = rom_mwait;
      REG_RAM: slave_ready = ram_mwait;
      default: slave_ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // armed marks the extra ACCESS cycle after the wait count expires, covering slave read latency.
  always_comb begin
    state_next  = state;
    region_nxt  = region;
    write_nxt   = write;
    cnt_nxt     = cnt;
    armed_nxt   = armed;
    rom_ena_nxt = rom_ena;
    ram_ena_nxt = ram_ena;
    wait_n_nxt  = cpu_wait_n;
    din_nxt     = cpu_din;
    complete    = 1'b0;
    ram_we      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next  = ACCESS;
          region_nxt  = hit;
          write_nxt   = cpu_rd_n;
          armed_nxt   = 1'b0;
          cnt_nxt     = (hit == REG_ROM) ? ROM_WAIT_C :
                        (hit == REG_RAM) ? RAM_WAIT_C : 4'd0;
          rom_ena_nxt = (hit == REG_ROM);
          ram_ena_nxt = (hit == REG_RAM);
          wait_n_nxt  = 1'b0;
        end
      end
      ACCESS: begin
        if (cpu_mreq_n) begin
          state_next  = IDLE;
          rom_ena_nxt = 1'b0;
          ram_ena_nxt = 1'b0;
          wait_n_nxt  = 1'b1;
        end else if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else if (!armed) begin
          armed_nxt = 1'b1;
        end else if (slave_ready) begin
          complete    = 1'b1;
          ram_we      = write && (region == REG_RAM);
          state_next  = DONE;
          rom_ena_nxt = 1'b0;
          ram_ena_nxt = 1'b0;
          wait_n_nxt  = 1'b1;
          if (!write) begin
            case (region)
              REG_ROM: din_nxt = rom_dout;
              REG_RAM: din_nxt = ram_dout;
              default: din_nxt = OPEN_BUS;
            endcase
          end
        end
      end
      DONE: begin
        if (cpu_mreq_n) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      region     <= REG_NONE;
      write      <= 1'b0;
      cnt        <= 4'd0;
      armed      <= 1'b0;
      rom_ena    <= 1'b0;
      ram_ena    <= 1'b0;
      cpu_wait_n <= 1'b1;
      cpu_din    <= OPEN_BUS;
    end else begin
      region     <= region_nxt;
      write      <= write_nxt;
      cnt        <= cnt_nxt;
      armed      <= armed_nxt;
      rom_ena    <= rom_ena_nxt;
      ram_ena    <= ram_ena_nxt;
      cpu_wait_n <= wait_n_nxt;
      cpu_din    <= din_nxt;
    end
  end

`ifdef Z80_DECODE_FAULT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      fault <= 1'b0;
    else if (complete && (region == REG_NONE || (region == REG_ROM && write)))
      fault <= 1'b1;
    else if (fault_clr)
      fault <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_z80_mem_decoder.sv
// Directed bench for z80_mem_decoder: default instance plus a RAM_WAIT=2 instance for the abort case.
module tb_z80_mem_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic        cpu_mreq_n, cpu_rd_n, cpu_wr_n;
  logic [7:0]  rom_dout, ram_dout;
  logic        rom_mwait, ram_mwait;
  logic        wait_a, rom_ena_a, ram_ena_a, ram_we_a;
  logic [7:0]  din_a;
  logic        wait_b, rom_ena_b, ram_ena_b, ram_we_b;
  logic [7:0]  din_b;
`ifdef Z80_DECODE_FAULT_EN
  logic        fault_a, fault_b, fault_clr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  z80_mem_decoder u_dut_a (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_mreq_n(cpu_mreq_n),
    .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_wait_n(wait_a), .cpu_din(din_a),
    .rom_ena(rom_ena_a), .rom_dout(rom_dout), .rom_mwait(rom_mwait),
    .ram_ena(ram_ena_a), .ram_we(ram_we_a), .ram_dout(ram_dout), .ram_mwait(ram_mwait)
`ifdef Z80_DECODE_FAULT_EN
    , .fault(fault_a), .fault_clr(fault_clr)
`endif
  );

  z80_mem_decoder #(.RAM_WAIT(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_mreq_n(cpu_mreq_n),
    .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_wait_n(wait_b), .cpu_din(din_b),
    .rom_ena(rom_ena_b), .rom_dout(rom_dout), .rom_mwait(rom_mwait),
    .ram_ena(ram_ena_b), .ram_we(ram_we_b), .ram_dout(ram_dout), .ram_mwait(ram_mwait)
`ifdef Z80_DECODE_FAULT_EN
    , .fault(fault_b), .fault_clr(fault_clr)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cpu_mreq_n = 1'b1;
    cpu_rd_n   = 1'b1;
    cpu_wr_n   = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus_idle();
    cpu_addr  = 16'h0000;
    rom_dout  = 8'h00;
    ram_dout  = 8'h00;
    rom_mwait = 1'b1;
    ram_mwait = 1'b1;
`ifdef Z80_DECODE_FAULT_EN
    fault_clr = 1'b0;
`endif
    step();
    step();
    checks++; if (rom_ena_a !== 1'b0) begin errors++; $display("FAIL reset_rom_ena got %b want 0", rom_ena_a); end
    checks++; if (ram_ena_a !== 1'b0) begin errors++; $display("FAIL reset_ram_ena got %b want 0", ram_ena_a); end
    checks++; if (ram_we_a !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %b want 0", ram_we_a); end
    checks++; if (wait_a !== 1'b1) begin errors++; $display("FAIL reset_wait_n got %b want 1", wait_a); end
    checks++; if (din_a !== 8'hFF) begin errors++; $display("FAIL reset_din got %h want FF", din_a); end
`ifdef Z80_DECODE_FAULT_EN
    checks++; if (fault_a !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", fault_a); end
`endif
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_rom_read();
    int wait_lo = 0, rom_hi = 0, ram_hi = 0;
    cpu_addr = 16'h0123; rom_dout = 8'hA5;
    cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (!wait_a) wait_lo++;
      if (rom_ena_a) rom_hi++;
      if (ram_ena_a) ram_hi++;
    end
    checks++; if (wait_lo != 3) begin errors++; $display("FAIL rom_read_wait_cycles got %0d want 3", wait_lo); end
    checks++; if (rom_hi != 3) begin errors++; $display("FAIL rom_read_ena_cycles got %0d want 3", rom_hi); end
    checks++; if (ram_hi != 0) begin errors++; $display("FAIL rom_read_ram_ena got %0d want 0", ram_hi); end
    checks++; if (din_a !== 8'hA5) begin errors++; $display("FAIL rom_read_din got %h want A5", din_a); end
    bus_idle();
    step();
    checks++; if (din_a !== 8'hA5) begin errors++; $display("FAIL rom_read_din_hold got %h want A5", din_a); end
  endtask

  task automatic test_ram_write();
    int ena_hi = 0, we_hi = 0, we_at = -1, wait_lo = 0;
    cpu_addr = 16'h8010;
    cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (ram_ena_a) ena_hi++;
      if (ram_we_a) begin we_hi++; we_at = i; end
      if (!wait_a) wait_lo++;
    end
    checks++; if (ena_hi != 2) begin errors++; $display("FAIL ram_write_ena_cycles got %0d want 2", ena_hi); end
    checks++; if (we_hi != 1) begin errors++; $display("FAIL ram_write_we_pulses got %0d want 1", we_hi); end
    checks++; if (we_at != 2) begin errors++; $display("FAIL ram_write_we_cycle got %0d want 2", we_at); end
    checks++; if (wait_lo != 2) begin errors++; $display("FAIL ram_write_wait_cycles got %0d want 2", wait_lo); end
    checks++; if (din_a !== 8'hA5) begin errors++; $display("FAIL ram_write_din_unchanged got %h want A5", din_a); end
    bus_idle();
    step();
  endtask

  task automatic test_unmapped();
    int ena_hi = 0, wait_lo = 0;
    cpu_addr = 16'h4000;
    cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (rom_ena_a || ram_ena_a) ena_hi++;
      if (!wait_a) wait_lo++;
    end
    checks++; if (ena_hi != 0) begin errors++; $display("FAIL unmapped_ena got %0d want 0", ena_hi); end
    checks++; if (wait_lo != 2) begin errors++; $display("FAIL unmapped_wait_cycles got %0d want 2", wait_lo); end
    checks++; if (din_a !== 8'hFF) begin errors++; $display("FAIL unmapped_din got %h want FF", din_a); end
    bus_idle();
    step();
`ifdef Z80_DECODE_FAULT_EN
    step();
    checks++; if (fault_a !== 1'b1) begin errors++; $display("FAIL unmapped_fault_set got %b want 1", fault_a); end
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    checks++; if (fault_a !== 1'b0) begin errors++; $display("FAIL unmapped_fault_clr got %b want 0", fault_a); end
`endif
  endtask

  task automatic test_mwait_stall();
    int wait_lo = 0;
    cpu_addr = 16'h8020; ram_dout = 8'h3C; ram_mwait = 1'b0;
    cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!wait_a) wait_lo++;
    end
    ram_mwait = 1'b1;
    checks++; if (wait_lo != 5) begin errors++; $display("FAIL stall_wait_cycles got %0d want 5", wait_lo); end
    checks++; if (wait_a !== 1'b0) begin errors++; $display("FAIL stall_wait_at_rise got %b want 0", wait_a); end
    step();
    checks++; if (wait_a !== 1'b1) begin errors++; $display("FAIL stall_wait_release got %b want 1", wait_a); end
    checks++; if (din_a !== 8'h3C) begin errors++; $display("FAIL stall_din got %h want 3C", din_a); end
    bus_idle();
    step();
  endtask

  task automatic test_abort();
    int we_hi = 0, rom_hi = 0;
    cpu_addr = 16'h8030;
    cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    step();
    if (ram_we_b) we_hi++;
    step();
    if (ram_we_b) we_hi++;
    checks++; if (ram_ena_b !== 1'b1) begin errors++; $display("FAIL abort_ena_before got %b want 1", ram_ena_b); end
    cpu_mreq_n = 1'b1;
    #1;
    if (ram_we_b) we_hi++;
    step();
    if (ram_we_b) we_hi++;
    checks++; if (ram_ena_b !== 1'b0) begin errors++; $display("FAIL abort_ena_drop got %b want 0", ram_ena_b); end
    checks++; if (wait_b !== 1'b1) begin errors++; $display("FAIL abort_wait_n got %b want 1", wait_b); end
    checks++; if (din_b !== 8'h3C) begin errors++; $display("FAIL abort_din_unchanged got %h want 3C", din_b); end
    bus_idle();
    step();
    if (ram_we_b) we_hi++;
    checks++; if (we_hi != 0) begin errors++; $display("FAIL abort_ram_we got %0d want 0", we_hi); end
    cpu_addr = 16'h0005; rom_dout = 8'h5A;
    cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rom_ena_b) rom_hi++;
    end
    checks++; if (rom_hi != 3) begin errors++; $display("FAIL abort_next_ena_cycles got %0d want 3", rom_hi); end
    checks++; if (din_b !== 8'h5A) begin errors++; $display("FAIL abort_next_din got %h want 5A", din_b); end
    bus_idle();
    step();
  endtask

  task automatic test_reset_mid();
    cpu_addr = 16'h0100; rom_dout = 8'h77;
    cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    step();
    step();
    checks++; if (rom_ena_a !== 1'b1) begin errors++; $display("FAIL midreset_ena_before got %b want 1", rom_ena_a); end
    reset_n = 1'b0;
    #1;
    checks++; if (rom_ena_a !== 1'b0) begin errors++; $display("FAIL midreset_rom_ena got %b want 0", rom_ena_a); end
    checks++; if (wait_a !== 1'b1) begin errors++; $display("FAIL midreset_wait_n got %b want 1", wait_a); end
    checks++; if (din_a !== 8'hFF) begin errors++; $display("FAIL midreset_din got %h want FF", din_a); end
    checks++; if (ram_we_a !== 1'b0) begin errors++; $display("FAIL midreset_ram_we got %b want 0", ram_we_a); end
    bus_idle();
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_rom_read();
    test_ram_write();
    test_unmapped();
    test_mwait_stall();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
